// File: rtl/hazard_ctrl_if.sv
// Hazard-unit interface: bundles the pipeline-side inputs and the stall/forward
// outputs of hazard_ctrl.
//   master : pipeline side, drives register ids / enables, receives controls
//   slave  : hazard_ctrl side
// Parameters: REG_AW register-address width, CNT_W stall-counter width.
interface hazard_ctrl_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 32
);
  logic              BranchD;
  logic [REG_AW-1:0] RsD, RtD;
  logic [REG_AW-1:0] RsE, RtE;
  logic [REG_AW-1:0] WriteRegE;
  logic              RegWriteE, MemToRegE;
  logic [REG_AW-1:0] WriteRegM;
  logic              RegWriteM, MemToRegM;
  logic [REG_AW-1:0] WriteRegW;
  logic              RegWriteW;
  logic              MdStartE;
  logic              MdUseD;
  logic              StallF, StallD, FlushE;
  logic              ForwardAD, ForwardBD;
  logic [1:0]        ForwardAE, ForwardBE;
  logic              MdBusy;
  logic [CNT_W-1:0]  StallCount;

  modport master (
    output BranchD, RsD, RtD, RsE, RtE, WriteRegE, RegWriteE, MemToRegE,
           WriteRegM, RegWriteM, MemToRegM, WriteRegW, RegWriteW, MdStartE, MdUseD,
    input  StallF, StallD, FlushE, ForwardAD, ForwardBD, ForwardAE, ForwardBE,
           MdBusy, StallCount
  );

  modport slave (
    input  BranchD, RsD, RtD, RsE, RtE, WriteRegE, RegWriteE, MemToRegE,
           WriteRegM, RegWriteM, MemToRegM, WriteRegW, RegWriteW, MdStartE, MdUseD,
    output StallF, StallD, FlushE, ForwardAD, ForwardBD, ForwardAE, ForwardBE,
           MdBusy, StallCount
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard unit for a 5-stage MIPS-style core.
// Produces operand forwarding selects for Execute and Decode-compare, load-use,
// branch and mult/div stalls, a mult/div busy tracker and an optional
// stall-cycle performance counter.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (clears busy tracker and counter)
//   hz    : hazard_ctrl_if.slave (pipeline inputs, stall/forward outputs)
// Parameters: REG_AW register-address width, MD_LAT mult/div busy cycles
//   (1..15), CNT_W stall-counter width (must match the interface).
// Build option: define HAZARD_PERF_CNT_EN to enable the saturating StallCount
//   counter; otherwise StallCount is tied to zero.
module hazard_ctrl #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned MD_LAT = 4,
  parameter int unsigned CNT_W  = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  hazard_ctrl_if.slave hz
);

  localparam logic [REG_AW-1:0] RegZero = '0;
  localparam logic [3:0]        MdLat   = 4'(MD_LAT);

  logic       rs_d_nz, rt_d_nz, rs_e_nz, rt_e_nz;
  logic       lwstall, brstall, mdstall, stall;
  logic [3:0] md_cnt_q, md_cnt_d;
  logic       md_busy;

  // Register 0 is hardwired, so a zero source never creates a hazard.
  assign rs_d_nz = (hz.RsD != RegZero);
  assign rt_d_nz = (hz.RtD != RegZero);
  assign rs_e_nz = (hz.RsE != RegZero);
  assign rt_e_nz = (hz.RtE != RegZero);

  // Execute-stage forwarding; Memory result is newer than Writeback.
  always_comb begin
    hz.ForwardAE = 2'b00;
    if (rs_e_nz && hz.RegWriteM && (hz.WriteRegM == hz.RsE))      hz.ForwardAE = 2'b10;
    else if (rs_e_nz && hz.RegWriteW && (hz.WriteRegW == hz.RsE)) hz.ForwardAE = 2'b01;

    hz.ForwardBE = 2'b00;
    if (rt_e_nz && hz.RegWriteM && (hz.WriteRegM == hz.RtE))      hz.ForwardBE = 2'b10;
    else if (rt_e_nz && hz.RegWriteW && (hz.WriteRegW == hz.RtE)) hz.ForwardBE = 2'b01;
  end

  assign hz.ForwardAD = rs_d_nz && hz.RegWriteM && (hz.WriteRegM == hz.RsD);
  assign hz.ForwardBD = rt_d_nz && hz.RegWriteM && (hz.WriteRegM == hz.RtD);

  assign lwstall = hz.MemToRegE &&
                   ((rs_d_nz && (hz.RtE == hz.RsD)) || (rt_d_nz && (hz.RtE == hz.RtD)));

  // Branch compares in Decode: an ALU result still in Execute or a load still
  // in Memory cannot be forwarded in time.
  assign brstall = hz.BranchD &&
                   ((hz.RegWriteE && ((rs_d_nz && (hz.WriteRegE == hz.RsD)) ||
                                      (rt_d_nz && (hz.WriteRegE == hz.RtD)))) ||
                    (hz.MemToRegM && ((rs_d_nz && (hz.WriteRegM == hz.RsD)) ||
                                      (rt_d_nz && (hz.WriteRegM == hz.RtD)))));

  // Busy counter: (re)load on issue, otherwise count down to zero.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (hz.MdStartE)             md_cnt_d = MdLat;
    else if (md_cnt_q != 4'd0)   md_cnt_d = md_cnt_q - 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) md_cnt_q <= 4'd0;
    else        md_cnt_q <= md_cnt_d;
  end

  assign md_busy   = (md_cnt_q != 4'd0);
  assign hz.MdBusy = md_busy;

  // The issue cycle itself also stalls a dependent Decode instruction.
  assign mdstall = hz.MdUseD && (md_busy || hz.MdStartE);

  assign stall     = lwstall || brstall || mdstall;
  assign hz.StallF = stall;
  assign hz.StallD = stall;
  assign hz.FlushE = stall;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of stalled Decode cycles.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign hz.StallCount = stall_cnt_q;
`else
  assign hz.StallCount = {CNT_W{1'b0}};
`endif

endmodule
